// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter giving two requesters access to a bank of N JK flip-flops.
// Each accepted operation runs IDLE -> DRIVE -> SETTLE, with q updated at the end of DRIVE.
`timescale 1ns/1ps
module jk_bank_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [2:0]   req0_idx,
    input  logic [1:0]   req0_op,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_idx,
    input  logic [1:0]   req1_op,
    output logic         req1_ready,
    output logic [N-1:0] j_vec,
    output logic [N-1:0] k_vec,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         grant_id,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic [N-1:0] r_j;
    logic [N-1:0] r_k;
    logic [N-1:0] r_q;
    logic         r_err;

    logic         w_accept;
    logic         w_gnt;
    logic [2:0]   w_idx;
    logic [1:0]   w_op;
    logic [N-1:0] w_j_nxt;
    logic [N-1:0] w_k_nxt;
    logic [N-1:0] w_q_nxt;
    logic         w_err_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, arbitration and the J/K drive for the DRIVE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_gnt       = r_last_grant;
        w_idx       = req0_idx;
        w_op        = req0_op;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_j_nxt     = '0;
        w_k_nxt     = '0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    w_accept    = 1'b1;
                    w_gnt       = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
                    w_idx       = w_gnt ? req1_idx : req0_idx;
                    w_op        = w_gnt ? req1_op  : req0_op;
                    req0_ready  = ~w_gnt;
                    req1_ready  = w_gnt;
                    w_state_nxt = S_DRIVE;
                    w_err_nxt   = 32'(w_idx) >= N;
                    for (int unsigned i = 0; i < N; i++) begin
                        if (32'(w_idx) == i) begin
                            w_j_nxt[i] = w_op[1];
                            w_k_nxt[i] = w_op[0];
                        end
                    end
                end
            end
            S_DRIVE:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // J/K are zero outside DRIVE, so applying the JK rule every cycle only changes q at the end of DRIVE.
    always_comb begin
        w_q_nxt = r_q;
        for (int unsigned i = 0; i < N; i++) begin
            case ({r_j[i], r_k[i]})
                2'b01:   w_q_nxt[i] = 1'b0;
                2'b10:   w_q_nxt[i] = 1'b1;
                2'b11:   w_q_nxt[i] = ~r_q[i];
                default: w_q_nxt[i] = r_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_j          <= '0;
            r_k          <= '0;
            r_q          <= '0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_j   <= w_j_nxt;
            r_k   <= w_k_nxt;
            r_q   <= w_q_nxt;
            r_err <= w_err_nxt;
            if (w_accept) r_last_grant <= w_gnt;
        end
    end

    assign j_vec    = r_j;
    assign k_vec    = r_k;
    assign q        = r_q;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_last_grant;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: N=8 and N=4 instances share stimulus and are checked
// every cycle against a cycle-countdown reference model of the arbitration and JK bank.
`timescale 1ns/1ps
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_idx, req1_idx;
    logic [1:0] req0_op, req1_op;

    logic       r0_8, r1_8, busy8, gid8, err8;
    logic [7:0] j8, k8, q8;
    logic       r0_4, r1_4, busy4, gid4, err4;
    logic [3:0] j4, k4, q4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int         m_left;
    logic       m_last;
    logic [7:0] m_q8;
    logic [7:0] m_q4;
    int         m_idx;
    logic [1:0] m_op;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.N(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_op(req0_op), .req0_ready(r0_8),
        .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_op(req1_op), .req1_ready(r1_8),
        .j_vec(j8), .k_vec(k8), .q(q8), .busy(busy8), .grant_id(gid8), .err(err8)
    );

    jk_bank_arbiter #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_op(req0_op), .req0_ready(r0_4),
        .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_op(req1_op), .req1_ready(r1_4),
        .j_vec(j4), .k_vec(k4), .q(q4), .busy(busy4), .grant_id(gid4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] jk_apply(input logic [7:0] qv, input int idx,
                                            input logic [1:0] op, input int n);
        logic [7:0] r;
        r = qv;
        if (idx < n) begin
            case (op)
                2'b01:   r[idx] = 1'b0;
                2'b10:   r[idx] = 1'b1;
                2'b11:   r[idx] = ~r[idx];
                default: r[idx] = r[idx];
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_drive(input logic bit_on, input int n);
        if (m_left == 2 && bit_on && m_idx < n) return 8'(1) << m_idx;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_last = 1'b1;
        m_q8   = 8'h00;
        m_q4   = 8'h00;
        m_idx  = 0;
        m_op   = 2'b00;
    endtask

    task automatic check_outputs();
        chk("busy8", 32'(busy8), 32'(m_left != 0));
        chk("busy4", 32'(busy4), 32'(m_left != 0));
        chk("gid8",  32'(gid8),  32'(m_last));
        chk("gid4",  32'(gid4),  32'(m_last));
        chk("q8",    32'(q8),    32'(m_q8));
        chk("q4",    32'(q4),    32'(m_q4));
        chk("j8",    32'(j8),    32'(exp_drive(m_op[1], 8)));
        chk("k8",    32'(k8),    32'(exp_drive(m_op[0], 8)));
        chk("j4",    32'(j4),    32'(exp_drive(m_op[1], 4)));
        chk("k4",    32'(k4),    32'(exp_drive(m_op[0], 4)));
        chk("err8",  32'(err8),  32'(m_left == 2 && m_idx >= 8));
        chk("err4",  32'(err4),  32'(m_left == 2 && m_idx >= 4));
    endtask

    // One clock cycle: check held outputs, apply inputs, check ready, step the model.
    task automatic cyc(input logic rs, input logic v0, input logic [2:0] i0, input logic [1:0] o0,
                       input logic v1, input logic [2:0] i1, input logic [1:0] o1);
        logic acc, win;
        @(negedge clk);
        check_outputs();
        reset      = rs;
        req0_valid = v0; req0_idx = i0; req0_op = o0;
        req1_valid = v1; req1_idx = i1; req1_op = o1;
        if (rs) model_reset();
        #1;
        if (rs) check_outputs();
        acc = !rs && m_left == 0 && (v0 || v1);
        win = (v0 && v1) ? ~m_last : v1;
        chk("rdy", {28'd0, r0_8, r1_8, r0_4, r1_4},
            {28'd0, acc && !win, acc && win, acc && !win, acc && win});
        if (m_left == 2) begin
            m_q8   = jk_apply(m_q8, m_idx, m_op, 8);
            m_q4   = jk_apply(m_q4, m_idx, m_op, 4);
            m_left = 1;
        end else if (m_left == 1) begin
            m_left = 0;
        end else if (acc) begin
            m_left = 2;
            m_last = win;
            m_idx  = win ? int'(i1) : int'(i0);
            m_op   = win ? o1 : o0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_idx = 3'd0; req0_op = 2'd0;
        req1_valid = 1'b0; req1_idx = 3'd0; req1_op = 2'd0;
        model_reset();
        cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0);
        cyc(1'b1, 1'b1, 3'd1, 2'd2, 1'b1, 3'd1, 2'd2);
        idle(1);

        // Single set on idx 2.
        cyc(1'b0, 1'b1, 3'd2, 2'b10, 1'b0, 3'd0, 2'd0);
        idle(3);
        chk("q_set2", 32'(q8), 32'h04);

        // Both requesters toggling continuously.
        cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 3'd0, 2'b11, 1'b1, 3'd1, 2'b11);
        idle(3);
        chk("q_alt", 32'(q8), 32'h00);

        // Set, then reset bit, then hold on same bit.
        cyc(1'b0, 1'b1, 3'd2, 2'b10, 1'b0, 3'd0, 2'd0);
        idle(2);
        cyc(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd2, 2'b01);
        idle(2);
        cyc(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd2, 2'b00);
        idle(3);
        chk("q_hold", 32'(q8), 32'h00);

        // Out-of-range index for the N=4 bank, then valid pulses during DRIVE/SETTLE.
        cyc(1'b0, 1'b1, 3'd7, 2'b10, 1'b0, 3'd0, 2'd0);
        cyc(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd3, 2'b10);
        cyc(1'b0, 1'b1, 3'd3, 2'b10, 1'b0, 3'd0, 2'd0);
        idle(2);
        chk("q4_oor", 32'(q4), 32'h0);

        // Reset mid-DRIVE, then simultaneous request.
        cyc(1'b0, 1'b1, 3'd5, 2'b10, 1'b0, 3'd0, 2'd0);
        cyc(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0);
        cyc(1'b0, 1'b1, 3'd1, 2'b10, 1'b1, 3'd6, 2'b10);
        idle(3);
        chk("q_after_rst", 32'(q8), 32'h02);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
